axi_packet: RTL and testbench



---
 rtl/axi_packet.sv | 139 +++++++++++++
 tb/tb_axi_packet.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_packet.sv
// axi_packet: AXI4 INCR-burst memory slave; range/SIZE errors give SLVERR without touching memory.
// Define AXI_BOUNDARY_CHECK_EN to also reject bursts that cross a 4 KB boundary.
module axi_packet #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WVALID,
  input  logic                  WLAST,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);
  localparam int IW = ADDR_WIDTH + 12;
  localparam int XW = $clog2(MEMORY_DEPTH);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_t;
  typedef enum logic {R_IDLE, R_DATA} rst_t;
  logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];
  wst_t r_wst, w_wst_nx;
  rst_t r_rst, w_rst_nx;
  logic r_live, r_werr, r_rerr;
  logic [IW-1:0] r_waddr, r_raddr;
  logic [7:0] r_wlen, r_wbeat, r_rlen, r_rbeat;
  logic [2:0] r_wsize, r_rsize;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_aw_err, w_ar_err, w_unused;
  logic [XW-1:0] w_wword, w_rword_ar, w_rword_nx;

  function automatic logic f_err(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] l, input logic [2:0] s);
    logic [IW-1:0] w_a, w_n;
    w_a = IW'(a);
    w_n = IW'(l) + IW'(1);
`ifdef AXI_BOUNDARY_CHECK_EN
    return ((w_a >> 2) + w_n > IW'(MEMORY_DEPTH)) || (s > 3'd2) || (IW'(w_a[11:0]) + (w_n << s) > IW'(4096));
`else
    return ((w_a >> 2) + w_n > IW'(MEMORY_DEPTH)) || (s > 3'd2);
`endif
  endfunction

  assign w_aw_hs    = AWVALID && AWREADY;
  assign w_w_hs     = WVALID && WREADY;
  assign w_b_hs     = BVALID && BREADY;
  assign w_ar_hs    = ARVALID && ARREADY;
  assign w_r_hs     = RVALID && RREADY;
  assign w_aw_err   = f_err(AWADDR, AWLEN, AWSIZE);
  assign w_ar_err   = f_err(ARADDR, ARLEN, ARSIZE);
  assign w_wword    = XW'((r_waddr + (IW'(r_wbeat) << r_wsize)) >> 2);
  assign w_rword_ar = XW'(ARADDR >> 2);
  assign w_rword_nx = XW'((r_raddr + (IW'(r_rbeat + 8'd1) << r_rsize)) >> 2);
  // The burst length is taken from AWLEN alone, so WLAST carries no meaning here.
  assign w_unused   = WLAST;

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      r_wst  <= W_IDLE;
      r_rst  <= R_IDLE;
      r_live <= 1'b0;
    end else begin
      r_wst  <= w_wst_nx;
      r_rst  <= w_rst_nx;
      r_live <= 1'b1;
    end

  always_comb begin
    w_wst_nx = (r_wst == W_IDLE && w_aw_hs) ? W_DATA :
               (r_wst == W_DATA && w_w_hs && r_wbeat == r_wlen) ? W_RESP :
               (r_wst == W_RESP && w_b_hs) ? W_IDLE : r_wst;
    w_rst_nx = w_ar_hs ? R_DATA : (w_r_hs && RLAST) ? R_IDLE : r_rst;
  end

  always_comb begin
    AWREADY = r_live && r_wst == W_IDLE;
    WREADY  = r_wst == W_DATA;
    BVALID  = r_wst == W_RESP;
    BRESP   = (BVALID && r_werr) ? 2'b10 : 2'b00;
    ARREADY = r_live && r_rst == R_IDLE;
    RVALID  = r_rst == R_DATA;
    RRESP   = (RVALID && r_rerr) ? 2'b10 : 2'b00;
    RLAST   = RVALID && r_rbeat == r_rlen;
    RDATA   = r_rdata;
  end

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      r_waddr <= '0;
      r_wlen  <= '0;
      r_wsize <= '0;
      r_werr  <= 1'b0;
      r_wbeat <= '0;
      r_raddr <= '0;
      r_rlen  <= '0;
      r_rsize <= '0;
      r_rerr  <= 1'b0;
      r_rbeat <= '0;
      r_rdata <= '0;
    end else begin
      if (w_aw_hs) begin
        r_waddr <= IW'(AWADDR);
        r_wlen  <= AWLEN;
        r_wsize <= AWSIZE;
        r_werr  <= w_aw_err;
        r_wbeat <= '0;
      end else if (w_w_hs) r_wbeat <= r_wbeat + 8'd1;
      // Read data is prefetched one beat ahead so RDATA is registered and holds while stalled.
      if (w_ar_hs) begin
        r_raddr <= IW'(ARADDR);
        r_rlen  <= ARLEN;
        r_rsize <= ARSIZE;
        r_rerr  <= w_ar_err;
        r_rbeat <= '0;
        r_rdata <= w_ar_err ? '0 : r_mem[w_rword_ar];
      end else if (w_r_hs && !RLAST) begin
        r_rbeat <= r_rbeat + 8'd1;
        r_rdata <= r_rerr ? '0 : r_mem[w_rword_nx];
      end
    end

  always_ff @(posedge ACLK)
    if (w_w_hs && !r_werr) r_mem[w_wword] <= WDATA;
endmodule

// File: tb/tb_axi_packet.sv
// tb_axi_packet: directed bursts checked against a queue-based memory model of the slave.
module tb_axi_packet;
  logic ACLK = 1'b0, ARESETn;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0] BRESP, RRESP;
  typedef struct { logic [31:0] d; logic [1:0] r; logic l; } rexp_t;
  rexp_t rq[$];
  logic [1:0] bq[$];
  logic [31:0] m [1024];
  int tests = 0, fails = 0;

  axi_packet dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit model_err(int a, int len, int sz);
    bit e;
    e = (a / 4 + len + 1 > 1024) || sz > 2;
`ifdef AXI_BOUNDARY_CHECK_EN
    e = e || (a % 4096) + (len + 1) * (1 << sz) > 4096;
`endif
    return e;
  endfunction

  function automatic int widx(int a, int b, int sz);
    return ((a + b * (1 << sz)) / 4) % 1024;
  endfunction

  always @(negedge ACLK) if (ARESETn) begin
    if (RVALID) begin
      if (rq.size() == 0) begin
        tests++; fails++;
        $display("FAIL r_unexpected: RVALID high with no beat outstanding");
      end else begin
        chk("rdata", RDATA, rq[0].d);
        chk("rresp", 32'(RRESP), 32'(rq[0].r));
        chk("rlast", 32'(RLAST), 32'(rq[0].l));
        if (RREADY) void'(rq.pop_front());
      end
    end
    if (BVALID && BREADY) begin
      if (bq.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected: BVALID high with no response outstanding");
      end else chk("bresp", 32'(BRESP), 32'(bq.pop_front()));
    end
  end

  task automatic check_rst_vals();
    chk("rst_awready", 32'(AWREADY), 0);
    chk("rst_wready", 32'(WREADY), 0);
    chk("rst_bvalid", 32'(BVALID), 0);
    chk("rst_bresp", 32'(BRESP), 0);
    chk("rst_arready", 32'(ARREADY), 0);
    chk("rst_rvalid", 32'(RVALID), 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_rresp", 32'(RRESP), 0);
    chk("rst_rlast", 32'(RLAST), 0);
  endtask

  task automatic do_reset();
    WVALID = 1'b0;
    ARESETn = 1'b0;
    #1;
    check_rst_vals();
    bq.delete();
    rq.delete();
    #20;
    ARESETn = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("awready_after_rst", 32'(AWREADY), 1);
  endtask

  task automatic write_burst(int a, int len, int sz, logic [31:0] base, int bstall, int abort);
    bit e;
    int n;
    e = model_err(a, len, sz);
    @(posedge ACLK); #1;
    bq.push_back(e ? 2'b10 : 2'b00);
    AWADDR = 16'(a); AWLEN = 8'(len); AWSIZE = 3'(sz); AWVALID = 1'b1;
    n = 0; @(negedge ACLK);
    while (!AWREADY && n < 100) begin @(negedge ACLK); n++; end
    chk("aw_timeout", 32'(n >= 100), 0);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (b == abort) begin
        do_reset();
        return;
      end
      WDATA = base + 32'(b); WLAST = (b == len); WVALID = 1'b1;
      n = 0; @(negedge ACLK);
      while (!WREADY && n < 100) begin @(negedge ACLK); n++; end
      chk("w_timeout", 32'(n >= 100), 0);
      if (!e) m[widx(a, b, sz)] = base + 32'(b);
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
    for (int k = 0; k < bstall; k++) begin
      @(negedge ACLK);
      chk("bvalid_hold", 32'(BVALID), 1);
      @(posedge ACLK); #1;
    end
    BREADY = 1'b1;
    n = 0; @(negedge ACLK);
    while (!BVALID && n < 100) begin @(negedge ACLK); n++; end
    chk("b_timeout", 32'(n >= 100), 0);
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  task automatic read_burst(int a, int len, int sz, int stall);
    bit e;
    int n, got, st;
    rexp_t x;
    e = model_err(a, len, sz);
    @(posedge ACLK); #1;
    for (int b = 0; b <= len; b++) begin
      x.d = e ? 32'h0 : m[widx(a, b, sz)];
      x.r = e ? 2'b10 : 2'b00;
      x.l = (b == len);
      rq.push_back(x);
    end
    ARADDR = 16'(a); ARLEN = 8'(len); ARSIZE = 3'(sz); ARVALID = 1'b1;
    n = 0; @(negedge ACLK);
    while (!ARREADY && n < 100) begin @(negedge ACLK); n++; end
    chk("ar_timeout", 32'(n >= 100), 0);
    @(posedge ACLK); #1;
    ARVALID = 1'b0; RREADY = 1'b1;
    got = 0; st = stall; n = 0;
    while (got <= len && n < 200) begin
      @(negedge ACLK); n++;
      if (RVALID && RREADY) got++;
      @(posedge ACLK); #1;
      RREADY = !(got == 1 && st > 0 && len >= 1);
      if (!RREADY) st--;
    end
    RREADY = 1'b0;
    chk("r_timeout", 32'(n >= 200), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 1'b0;
    WDATA = '0; WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 1'b0; RREADY = 1'b0;
    ARESETn = 1'b0;
    #1;
    check_rst_vals();
    #30;
    ARESETn = 1'b1;
    chk("pin_err_ok", 32'(model_err(16'h0010, 3, 2)), 0);
    chk("pin_err_oor", 32'(model_err(16'h1000, 0, 2)), 1);
    chk("pin_err_straddle", 32'(model_err(16'h0FF8, 3, 2)), 1);
    chk("pin_err_size", 32'(model_err(0, 0, 3)), 1);
    write_burst(16'h0010, 3, 2, 32'hA0, 0, -1);
    chk("pin_m4", m[4], 32'hA0);
    chk("pin_m7", m[7], 32'hA3);
    read_burst(16'h0010, 3, 2, 3);
    write_burst(16'h1000, 0, 2, 32'hDEAD, 0, -1);
    read_burst(16'h1000, 0, 2, 0);
    write_burst(16'h0FF8, 1, 2, 32'h11, 0, -1);
    write_burst(16'h0FF8, 3, 2, 32'h55, 2, -1);
    chk("pin_m1022", m[1022], 32'h11);
    chk("pin_m1023", m[1023], 32'h12);
    read_burst(16'h0FF8, 1, 2, 0);
    read_burst(16'h0FFC, 1, 2, 0);
    write_burst(16'h0020, 3, 1, 32'h70, 0, -1);
    chk("pin_m8", m[8], 32'h71);
    chk("pin_m9", m[9], 32'h73);
    read_burst(16'h0020, 1, 2, 1);
    read_burst(16'h0020, 0, 3, 0);
    write_burst(16'h0100, 7, 2, 32'hC0, 0, 2);
    chk("pin_m65", m[65], 32'hC1);
    write_burst(16'h0200, 1, 2, 32'hE0, 1, -1);
    read_burst(16'h0100, 1, 2, 0);
    read_burst(16'h0200, 1, 2, 2);
    repeat (3) @(posedge ACLK);
    chk("rq_drained", 32'(rq.size()), 0);
    chk("bq_drained", 32'(bq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
